// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ctrl_seq instruction sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IC_NOP  = 3'd0,
    IC_ALU  = 3'd1,
    IC_BR   = 3'd2,
    IC_LD   = 3'd3,
    IC_ST   = 3'd4,
    IC_HALT = 3'd5
  } iclass_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ALU_EX,
    S_ST_EX,
    S_LD_RD,
    S_LD_WAIT,
    S_LD_WB,
    S_BR_EVAL,
    S_BR_HOLD,
    S_BR_DONE,
    S_NOP_EX,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_CMP = 3'b011;

endpackage

// File: rtl/ctrl_seq_sat_ctr16.sv
// sat_ctr16: 16-bit up-counter with enable that sticks at 16'hFFFF.
module sat_ctr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= 16'h0000;
    else if (en && (cnt != 16'hFFFF))
      cnt <= cnt + 16'h0001;
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer (ALU / branch / load / store / halt).
// Optional perf counters are built when CTRL_PERF_EN is defined.
//
// state     | meaning
// S_IDLE    | waiting for an instruction (ready unless halted)
// S_ALU_EX  | ALU op, writeback and PC advance
// S_ST_EX   | data-memory write and PC advance
// S_LD_RD   | data-memory address presented
// S_LD_WAIT | memory latency cycle, address held
// S_LD_WB   | register writeback and PC advance
// S_BR_EVAL | branch enable raised, compare issued
// S_BR_HOLD | branch held BR_WAIT cycles for PC_LUT/PC
// S_BR_DONE | PC advance only if branch not taken
// S_NOP_EX  | NOP or unencoded class, PC advance only
// S_HALT    | sticky halt until reset
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int OPW     = 3,
  parameter int AW      = 8,
  parameter int BR_WAIT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [2:0]     instr_class,
  input  logic [OPW-1:0] instr_op,
  input  logic [AW-1:0]  instr_addr,
  output logic [OPW-1:0] alu_cmd,
  input  logic           alu_taken,
  output logic           branch,
  output logic           pc_adv,
  output logic [AW-1:0]  dm_addr,
  output logic           dm_wr_en,
  output logic           rf_we,
  output logic           busy,
`ifdef CTRL_PERF_EN
  output logic [15:0]    perf_instr,
  output logic [15:0]    perf_taken,
`endif
  output logic           done
);

  state_t     state;
  logic [2:0] hold_cnt;

  // Outputs are registered alongside the state, so each branch below sets
  // the values belonging to the state being entered. alu_cmd/dm_addr double
  // as the latched opcode/address and hold between instructions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      hold_cnt    <= 3'd0;
      instr_ready <= 1'b0;
      alu_cmd     <= '0;
      branch      <= 1'b0;
      pc_adv      <= 1'b0;
      dm_addr     <= '0;
      dm_wr_en    <= 1'b0;
      rf_we       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pc_adv   <= 1'b0;
      dm_wr_en <= 1'b0;
      rf_we    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            case (instr_class)
              IC_ALU: begin
                state   <= S_ALU_EX;
                alu_cmd <= instr_op;
                rf_we   <= 1'b1;
                pc_adv  <= 1'b1;
              end
              IC_ST: begin
                state    <= S_ST_EX;
                dm_addr  <= instr_addr;
                dm_wr_en <= 1'b1;
                pc_adv   <= 1'b1;
              end
              IC_LD: begin
                state   <= S_LD_RD;
                dm_addr <= instr_addr;
              end
              IC_BR: begin
                state   <= S_BR_EVAL;
                alu_cmd <= instr_op;
                branch  <= 1'b1;
              end
              IC_HALT: begin
                state <= S_HALT;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
              default: begin
                state  <= S_NOP_EX;
                pc_adv <= 1'b1;
              end
            endcase
          end else begin
            instr_ready <= 1'b1;
          end
        end
        S_LD_RD: state <= S_LD_WAIT;
        S_LD_WAIT: begin
          state  <= S_LD_WB;
          rf_we  <= 1'b1;
          pc_adv <= 1'b1;
        end
        S_BR_EVAL: begin
          if (BR_WAIT == 0) begin
            state  <= S_BR_DONE;
            branch <= 1'b0;
            pc_adv <= !alu_taken;
          end else begin
            state    <= S_BR_HOLD;
            hold_cnt <= 3'(BR_WAIT - 1);
          end
        end
        S_BR_HOLD: begin
          // alu_taken is sampled on the last edge of the branch window
          if (hold_cnt == 3'd0) begin
            state  <= S_BR_DONE;
            branch <= 1'b0;
            pc_adv <= !alu_taken;
          end else begin
            hold_cnt <= hold_cnt - 3'd1;
          end
        end
        S_HALT: begin
          instr_ready <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          branch      <= 1'b0;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_EN
  logic retire;
  logic taken_ret;

  // A branch retires in BR_DONE; it was taken exactly when no PC advance is issued.
  assign retire    = (state == S_ALU_EX) || (state == S_ST_EX) || (state == S_LD_WB) ||
                     (state == S_NOP_EX) || (state == S_BR_DONE);
  assign taken_ret = (state == S_BR_DONE) && !pc_adv;

  sat_ctr16 u_perf_instr (
    .clk   (clk),
    .reset (reset),
    .en    (retire),
    .cnt   (perf_instr)
  );

  sat_ctr16 u_perf_taken (
    .clk   (clk),
    .reset (reset),
    .en    (taken_ret),
    .cnt   (perf_taken)
  );
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed, table-driven bench for ctrl_seq (BR_WAIT=1), with CTRL_PERF_EN checks when defined.
module tb_ctrl_seq;
  import ctrl_pkg::*;

  localparam int BRW = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_class = 3'd0;
  logic [2:0] instr_op = 3'd0;
  logic [7:0] instr_addr = 8'h00;
  logic [2:0] alu_cmd;
  logic       alu_taken = 1'b0;
  logic       branch, pc_adv, dm_wr_en, rf_we, busy, done;
  logic [7:0] dm_addr;
`ifdef CTRL_PERF_EN
  logic [15:0] perf_instr, perf_taken;
`endif

  ctrl_seq #(.OPW(3), .AW(8), .BR_WAIT(BRW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_class (instr_class),
    .instr_op    (instr_op),
    .instr_addr  (instr_addr),
    .alu_cmd     (alu_cmd),
    .alu_taken   (alu_taken),
    .branch      (branch),
    .pc_adv      (pc_adv),
    .dm_addr     (dm_addr),
    .dm_wr_en    (dm_wr_en),
    .rf_we       (rf_we),
    .busy        (busy),
`ifdef CTRL_PERF_EN
    .perf_instr  (perf_instr),
    .perf_taken  (perf_taken),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Global invariants: never both write strobes, never pc_adv two cycles running.
  int  overlap_cnt = 0;
  int  consec_cnt  = 0;
  logic prev_pc = 1'b0;
  always @(negedge clk) begin
    if (dm_wr_en && rf_we) overlap_cnt <= overlap_cnt + 1;
    if (pc_adv && prev_pc) consec_cnt <= consec_cnt + 1;
    prev_pc <= pc_adv;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] cls;
    logic [2:0] op;
    logic [7:0] addr;
    logic       tk;
    int         cyc;
    int         br;
    int         pc;
    int         rf;
    int         dw;
    logic [7:0] e_addr;
    logic [2:0] e_cmd;
  } vec_t;

  vec_t vecs[9];

  // Issue one instruction at a negedge, then profile it until ready returns.
  task automatic run_vec(input vec_t v, input string nm);
    int  cyc = 0, br = 0, pc = 0, rf = 0, dw = 0, bz = 0;
    bit  fin = 1'b0;
    check({nm, ".ready_before"}, int'(instr_ready), 1);
    instr_valid = 1'b1;
    instr_class = v.cls;
    instr_op    = v.op;
    instr_addr  = v.addr;
    alu_taken   = v.tk;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) begin
        fin = 1'b1;
        break;
      end
      cyc++;
      br += int'(branch);
      pc += int'(pc_adv);
      rf += int'(rf_we);
      dw += int'(dm_wr_en);
      bz += int'(busy);
      @(negedge clk);
    end
    check({nm, ".completed"}, int'(fin), 1);
    check({nm, ".cycles"}, cyc, v.cyc);
    check({nm, ".busy_cycles"}, bz, v.cyc);
    check({nm, ".branch_cycles"}, br, v.br);
    check({nm, ".pc_adv"}, pc, v.pc);
    check({nm, ".rf_we"}, rf, v.rf);
    check({nm, ".dm_wr_en"}, dw, v.dw);
    check({nm, ".dm_addr"}, int'(dm_addr), int'(v.e_addr));
    check({nm, ".alu_cmd"}, int'(alu_cmd), int'(v.e_cmd));
    check({nm, ".idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    logic [4:0] rf_pat, pc_pat, rdy_pat;
    logic [2:0] cmd_before;
    int         cnt_a, cnt_b, cnt_c, cnt_d, cnt_e;

    //       cls    op      addr   tk    cyc    br     pc rf dw  e_addr e_cmd
    vecs[0] = '{3'd2, OP_CMP, 8'h00, 1'b0, 2+BRW, 1+BRW, 1, 0, 0, 8'h00, 3'd3};
    vecs[1] = '{3'd2, OP_CMP, 8'h00, 1'b1, 2+BRW, 1+BRW, 0, 0, 0, 8'h00, 3'd3};
    vecs[2] = '{3'd4, 3'd5,   8'h02, 1'b0, 1,     0,     1, 0, 1, 8'h02, 3'd3};
    vecs[3] = '{3'd3, 3'd0,   8'h05, 1'b0, 3,     0,     1, 1, 0, 8'h05, 3'd3};
    vecs[4] = '{3'd1, 3'd6,   8'h77, 1'b0, 1,     0,     1, 1, 0, 8'h05, 3'd6};
    vecs[5] = '{3'd0, 3'd1,   8'h33, 1'b0, 1,     0,     1, 0, 0, 8'h05, 3'd6};
    vecs[6] = '{3'd7, 3'd2,   8'h44, 1'b1, 1,     0,     1, 0, 0, 8'h05, 3'd6};
    vecs[7] = '{3'd2, 3'd2,   8'h10, 1'b1, 2+BRW, 1+BRW, 0, 0, 0, 8'h05, 3'd2};
    vecs[8] = '{3'd4, 3'd7,   8'hFF, 1'b0, 1,     0,     1, 0, 1, 8'hFF, 3'd2};

    // Reset held 3 cycles: every output low, including instr_ready.
    repeat (3) @(negedge clk);
    check("rst.ready", int'(instr_ready), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.strobes", int'({branch, pc_adv, dm_wr_en, rf_we}), 0);
    check("rst.alu_cmd", int'(alu_cmd), 0);
    check("rst.dm_addr", int'(dm_addr), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel.ready", int'(instr_ready), 1);
    check("rel.busy", int'(busy), 0);
    check("rel.done", int'(done), 0);

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // LD followed by an ALU held on instr_valid: the ALU waits until after LD_WB.
    rf_pat = '0; pc_pat = '0; rdy_pat = '0;
    cmd_before = alu_cmd;
    instr_valid = 1'b1; instr_class = 3'd3; instr_addr = 8'h05; instr_op = 3'd0;
    @(negedge clk);
    instr_class = 3'd1; instr_op = 3'd4; instr_addr = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) check($sformatf("b2b.dm_addr_c%0d", c + 1), int'(dm_addr), 5);
      if (c < 3) check($sformatf("b2b.alu_cmd_c%0d", c + 1), int'(alu_cmd), int'(cmd_before));
      rf_pat  = {rf_pat[3:0], rf_we};
      pc_pat  = {pc_pat[3:0], pc_adv};
      rdy_pat = {rdy_pat[3:0], instr_ready};
      if (c == 4) begin
        check("b2b.alu_cmd_c5", int'(alu_cmd), 4);
        instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b.rf_we_pattern", int'(rf_pat), 5'b00101);
    check("b2b.pc_adv_pattern", int'(pc_pat), 5'b00101);
    check("b2b.ready_pattern", int'(rdy_pat), 5'b00010);
    check("b2b.ready_after", int'(instr_ready), 1);

    // Reset during LD_WAIT aborts the load with no late strobes.
    instr_valid = 1'b1; instr_class = 3'd3; instr_addr = 8'h09;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("abort.in_ld_wait", int'(dm_addr), 9);
    reset = 1'b0;
    #1;
    check("abort.busy_in_reset", int'(busy), 0);
    check("abort.strobes_in_reset", int'({pc_adv, rf_we, dm_wr_en}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cnt_a = 0; cnt_b = 0;
    repeat (5) begin
      @(negedge clk);
      cnt_a += int'(rf_we);
      cnt_b += int'(pc_adv);
    end
    check("abort.rf_we", cnt_a, 0);
    check("abort.pc_adv", cnt_b, 0);
    check("abort.idle_ready", int'(instr_ready), 1);
    check("abort.idle_busy", int'(busy), 0);

    // Non-taken then taken compare branch after the perf counters cleared.
    run_vec(vecs[0], "perf_br_nt");
    run_vec(vecs[1], "perf_br_tk");
`ifdef CTRL_PERF_EN
    check("perf.instr", int'(perf_instr), 2);
    check("perf.taken", int'(perf_taken), 1);
`endif

    // HALT, then an ALU instruction held valid for 10 cycles is never accepted.
    cmd_before = alu_cmd;
    instr_valid = 1'b1; instr_class = 3'd5; instr_op = 3'd0;
    @(negedge clk);
    instr_class = 3'd1; instr_op = 3'd6;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; cnt_e = 0;
    repeat (10) begin
      cnt_a += int'(done);
      cnt_b += int'(instr_ready);
      cnt_c += int'(pc_adv) + int'(rf_we) + int'(dm_wr_en) + int'(branch);
      cnt_d += int'(busy);
      cnt_e += int'(alu_cmd != cmd_before);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("halt.done_cycles", cnt_a, 10);
    check("halt.ready_cycles", cnt_b, 0);
    check("halt.strobes", cnt_c, 0);
    check("halt.busy_cycles", cnt_d, 0);
    check("halt.alu_cmd_changes", cnt_e, 0);
`ifdef CTRL_PERF_EN
    check("halt.perf_instr", int'(perf_instr), 2);
    check("halt.perf_taken", int'(perf_taken), 1);
`endif

    check("inv.wr_overlap", overlap_cnt, 0);
    check("inv.pc_adv_consecutive", consec_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
